// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The master drives operands and takes results; the slave is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic [3:0]       out_status;

  modport master (
    output in_valid, in_a, in_b, in_sel, out_ready,
    input  in_ready, out_valid, out_f, out_status
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, out_ready,
    output in_ready, out_valid, out_f, out_status
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and {V,C,N,Z} status.
// Op 3 is an iterative shift-add unsigned multiply when MUL_EN is set.
//
// state | meaning
// IDLE  | waiting for an operand; single-cycle ops complete here
// MUL   | shift-add multiply in progress, WIDTH cycles, in_ready low
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state, state_nxt;
  logic               valid_r, valid_nxt;
  logic [WIDTH-1:0]   f_r, f_nxt;
  logic [3:0]         st_r, st_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [SW-1:0]      cnt, cnt_nxt;

  logic [WIDTH-1:0]   bx;
  logic [WIDTH:0]     sum;
  logic [SW-1:0]      sh;
  logic [2:0]         op;
  logic [WIDTH-1:0]   alu_f;
  logic               alu_c;
  logic               alu_v;
  logic               accept;
  logic               is_mul;
  logic [2*WIDTH-1:0] prod_step;

  function automatic logic [3:0] make_status(input logic v, input logic c,
                                             input logic [WIDTH-1:0] f);
    return {v, c, f[WIDTH-1], (f == '0)};
  endfunction

  assign op     = bus.in_sel[2:0];
  assign bx     = bus.in_sel[3] ? ~bus.in_b : bus.in_b;
  assign sum    = {1'b0, bus.in_a} + {1'b0, bx} + {{WIDTH{1'b0}}, bus.in_sel[3]};
  assign sh     = bus.in_b[SW-1:0];
  assign is_mul = (op == 3'd3) && MUL_EN;

  assign bus.in_ready   = (state == IDLE) && (!valid_r || bus.out_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = valid_r;
  assign bus.out_f      = f_r;
  assign bus.out_status = st_r;

  assign prod_step = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      3'd0: begin
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = ~(bus.in_a[WIDTH-1] ^ bx[WIDTH-1]) & (sum[WIDTH-1] ^ bus.in_a[WIDTH-1]);
      end
      3'd1: alu_f = bus.in_a << sh;
      3'd2: alu_f = ~(bus.in_a | bx);
      3'd4: alu_f = bus.in_a ^ bx;
      3'd5: alu_f = bus.in_sel[3] ? $unsigned($signed(bus.in_a) >>> sh) : (bus.in_a >> sh);
      3'd6: alu_f = bus.in_a | bx;
      3'd7: alu_f = bus.in_a & bx;
      default: alu_f = '0;  // op 3 without the multiplier
    endcase
  end

  always_comb begin
    state_nxt  = state;
    valid_nxt  = valid_r;
    f_nxt      = f_r;
    st_nxt     = st_r;
    mcand_nxt  = mcand;
    acc_nxt    = acc;
    mplier_nxt = mplier;
    cnt_nxt    = cnt;

    if (valid_r && bus.out_ready) valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_nxt  = MUL;
            mcand_nxt  = {{WIDTH{1'b0}}, bus.in_a};
            mplier_nxt = bus.in_b;
            acc_nxt    = '0;
            cnt_nxt    = '0;
          end else begin
            f_nxt     = alu_f;
            st_nxt    = make_status(alu_v, alu_c, alu_f);
            valid_nxt = 1'b1;
          end
        end
      end
      MUL: begin
        acc_nxt    = prod_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          f_nxt     = prod_step[WIDTH-1:0];
          st_nxt    = make_status(|prod_step[2*WIDTH-1:WIDTH], 1'b0, prod_step[WIDTH-1:0]);
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid_r <= 1'b0;
      f_r     <= '0;
      st_r    <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      valid_r <= valid_nxt;
      f_r     <= f_nxt;
      st_r    <= st_nxt;
      mcand   <= mcand_nxt;
      acc     <= acc_nxt;
      mplier  <= mplier_nxt;
      cnt     <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=32, MUL_EN=1).
// Inputs change after the rising edge; outputs are sampled on the falling edge.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_pipe_if #(.WIDTH(32)) bus ();

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_f,
                        input logic [3:0] exp_st);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_sel    = sel;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_sel   = ~sel;
    @(negedge clk);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " f"}, bus.out_f, exp_f);
    check({tag, " status"}, 32'(bus.out_status), 32'(exp_st));
  endtask

  task automatic run_mul(input string tag, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_f,
                         input logic [3:0] exp_st);
    int lat;
    int busy;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sel    = sel;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    lat  = 0;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (!bus.in_ready) busy++;
      @(posedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd32);
    check({tag, " busy cycles"}, 32'(busy), 32'd32);
    check({tag, " f"}, bus.out_f, exp_f);
    check({tag, " status"}, 32'(bus.out_status), 32'(exp_st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = 4'b0000;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_f", bus.out_f, 32'd0);
    check("reset status", 32'(bus.out_status), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;

    run_op("add ovf",   4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1010);
    run_op("add carry", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101);
    run_op("sub eq",    4'b1000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0101);
    run_op("sub neg",   4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0010);
    run_op("sra",       4'b1101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b0010);
    run_op("srl",       4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 4'b0000);
    run_op("sll 31",    4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b0010);
    run_op("sll wrap",  4'b0001, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 4'b0000);
    run_op("nor",       4'b0010, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0010);
    run_op("nor inv",   4'b1010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001);
    run_op("xor",       4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000);
    run_op("or zero",   4'b0110, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001);
    run_op("and inv",   4'b1111, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000, 4'b0010);

    run_mul("mul ovf",  4'b0011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1001);
    run_mul("mul 7x6",  4'b0011, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 4'b0000);
    run_mul("mul max",  4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b1000);

    // Backpressure: result must hold while a second op waits.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sel    = 4'b0100;
    bus.in_a      = 32'h1234_5678;
    bus.in_b      = 32'h0000_0000;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_sel = 4'b0000;
    bus.in_a   = 32'd10;
    bus.in_b   = 32'd20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp f", bus.out_f, 32'h1234_5678);
      check("bp status", 32'(bus.out_status), 32'd0);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp drain in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b out_valid", 32'(bus.out_valid), 32'd1);
    check("b2b f", bus.out_f, 32'h0000_001E);
    check("b2b status", 32'(bus.out_status), 32'd0);
    @(negedge clk);
    check("drained out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a multiply drops it.
    bus.in_valid = 1'b1;
    bus.in_sel   = 4'b0011;
    bus.in_a     = 32'd7;
    bus.in_b     = 32'd6;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst mul out_valid", 32'(bus.out_valid), 32'd0);
    check("rst mul in_ready", 32'(bus.in_ready), 32'd1);
    check("rst mul f", bus.out_f, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post rst no result", 32'(bus.out_valid), 32'd0);
    run_op("add post rst", 4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
